// File: rtl/audio_frame_packer.sv
// audio_frame_packer
//   Buffers multi-channel sample frames in a small frame FIFO and serialises each one, MSB-first,
//   onto an 8-bit valid/ready byte stream as: sync byte, frame id, sample bytes.
//   Frames arriving while the packer is full are dropped and counted.
// Ports
//   IFCLK        sole clock, rising edge
//   RST_N        synchronous reset, active low
//   ENABLE       frames accepted only while high
//   FRAME_VALID  one-cycle strobe qualifying FRAME_DATA
//   FRAME_DATA   CHANNELS*SAMPLE_W frame, ch0L in the MSBs
//   BYTE_DATA    serialised byte (registered)
//   BYTE_VALID   BYTE_DATA valid (registered)
//   BYTE_READY   downstream accepts the byte this cycle
//   OVERFLOW     one-cycle pulse per dropped frame
//   DROP_COUNT   saturating count of dropped frames
//   LEVEL        frames queued, excluding the one in the serialiser
module audio_frame_packer #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned DEPTH     = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                           IFCLK,
  input  logic                           RST_N,
  input  logic                           ENABLE,
  input  logic                           FRAME_VALID,
  input  logic [CHANNELS*SAMPLE_W-1:0]   FRAME_DATA,
  output logic [7:0]                     BYTE_DATA,
  output logic                           BYTE_VALID,
  input  logic                           BYTE_READY,
  output logic                           OVERFLOW,
  output logic [15:0]                    DROP_COUNT,
  output logic [$clog2(DEPTH):0]         LEVEL
);

  localparam int unsigned FrameW = CHANNELS * SAMPLE_W;
  localparam int unsigned NBytes = FrameW / 8;
  localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LvlW   = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StSync, StId, StData} state_e;

  state_e            state_q, state_d;
  logic [FrameW-1:0] mem_data [DEPTH];
  logic [7:0]        mem_id   [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [7:0]        id_q, id_d;
  logic [FrameW-1:0] shift_q, shift_d;
  logic [7:0]        cur_id_q, cur_id_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              byte_valid_q, byte_valid_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_q, drop_d;

  logic            busy, hs, last, empty, full, pop, push, drop, fv_en;
  logic [LvlW:0]   occupancy;

  assign busy  = (state_q != StIdle);
  assign hs    = byte_valid_q & BYTE_READY;
  assign last  = (state_q == StData) && (idx_q == IdxW'(NBytes - 1));
  assign empty = (level_q == '0);

  // Capacity counts the frame in the serialiser, so DEPTH frames total can be held.
  assign occupancy = {1'b0, level_q} + {{LvlW{1'b0}}, busy};
  assign full      = (occupancy >= (LvlW + 1)'(DEPTH));

  assign fv_en = FRAME_VALID & ENABLE;
  assign push  = fv_en & (~full | pop);
  assign drop  = fv_en & full & ~pop;

  // Serialiser FSM and registered byte output.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cur_id_d    = cur_id_q;
    idx_d       = idx_q;
    byte_data_d = byte_data_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) pop = 1'b1;
      end
      StSync: begin
        if (hs) begin
          state_d     = StId;
          byte_data_d = cur_id_q;
        end
      end
      StId: begin
        if (hs) begin
          state_d     = StData;
          byte_data_d = shift_q[FrameW-1 -: 8];
          shift_d     = shift_q << 8;
          idx_d       = '0;
        end
      end
      StData: begin
        if (hs) begin
          if (last) begin
            if (!empty) begin
              pop = 1'b1;
            end else begin
              state_d     = StIdle;
              byte_data_d = 8'h00;
            end
          end else begin
            byte_data_d = shift_q[FrameW-1 -: 8];
            shift_d     = shift_q << 8;
            idx_d       = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Loading the head frame always restarts the byte sequence at the sync byte.
    if (pop) begin
      state_d     = StSync;
      shift_d     = mem_data[rd_ptr_q];
      cur_id_d    = mem_id[rd_ptr_q];
      byte_data_d = SYNC_BYTE;
    end
    byte_valid_d = (state_d != StIdle);
  end

  // FIFO bookkeeping, frame id and drop accounting.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PtrW'(push);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    level_d    = level_q + LvlW'(push) - LvlW'(pop);
    id_d       = id_q + 8'(push);
    overflow_d = drop;
    drop_d     = drop_q;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge IFCLK) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      id_q         <= '0;
      shift_q      <= '0;
      cur_id_q     <= '0;
      idx_q        <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      id_q         <= id_d;
      shift_q      <= shift_d;
      cur_id_q     <= cur_id_d;
      idx_q        <= idx_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge IFCLK) begin
    if (RST_N && push) begin
      mem_data[wr_ptr_q] <= FRAME_DATA;
      mem_id[wr_ptr_q]   <= id_q;
    end
  end

  assign BYTE_DATA  = byte_data_q;
  assign BYTE_VALID = byte_valid_q;
  assign OVERFLOW   = overflow_q;
  assign DROP_COUNT = drop_q;
  assign LEVEL      = level_q;

endmodule
